comparator_bist: RTL and testbench
==================================

// Module: comparator_bist
// PURPOSE
//  Sequential self-test engine for WIDTH-bit magnitude comparators: generates every {a,b} pair, reads back e/g/l.
//  Checks each result against the expected relation, counts mismatches and reports pass/fail.
//  Sits beside the comparator under test on-chip and replaces an external stimulus bench.
// PARAMETERS
//  WIDTH   2  operand width of the comparator under test (1..8)
//  SETTLE  1  cycles each vector is held before sampling e/g/l (>=1)
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin a sweep (sampled in IDLE or DONE only)
//  a          out  WIDTH    operand A to comparator under test (registered)
//  b          out  WIDTH    operand B to comparator under test (registered)
//  e          in   1        comparator equal result
//  g          in   1        comparator greater (a>b) result
//  l          in   1        comparator less (a<b) result
//  busy       out  1        sweep in progress
//  done       out  1        sweep finished; held until next start or rst
//  pass       out  1        valid with done: 1 = zero mismatches
//  err_count  out  2*WIDTH+1  number of mismatching vectors
//  first_fail out  2*WIDTH  {a,b} of first mismatch; valid when err_count!=0
// BEHAVIOUR
//  Reset: state IDLE; a=b=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
//  rst has priority over every other input; rst mid-sweep aborts to IDLE with reset values next cycle.
//  States: IDLE, DRIVE, SAMPLE, DONE.
//  IDLE/DONE + start=1 -> DRIVE; vec=0, err_count=0, first_fail=0, done=0, pass=0, busy=1.
//  {a,b} = vec (a = upper WIDTH bits) driven from the cycle DRIVE is entered.
//  DRIVE: held exactly SETTLE cycles (settle counter), then -> SAMPLE.
//  SAMPLE (1 cycle): expected = {a==b, a>b, a<b} unsigned; mismatch if {e,g,l} != expected
//   (covers non-one-hot outputs). On mismatch: err_count+1; if err_count was 0, first_fail=vec.
//  After SAMPLE: vec != all-ones -> vec+1, DRIVE; vec == all-ones -> DONE.
//  DONE: busy=0, done=1, pass=(err_count==0); a,b hold last vector.
//  Per vector SETTLE+1 cycles; full sweep 2^(2*WIDTH)*(SETTLE+1) cycles busy.
//  start while busy is ignored; start held high in DONE restarts every cycle it is seen in DONE.
//  err_count width holds 2^(2*WIDTH) -> no overflow/saturation needed.
//  e/g/l treated as synchronous to clk; no internal synchroniser.
// CONFIGURATION
//  COMP_BIST_STOP_ON_FAIL_EN defined: first mismatch in SAMPLE -> DONE immediately;
//   err_count=1, pass=0, a/b frozen at failing vector (== first_fail).
//  Not defined: sweep always runs to vec all-ones, counting every mismatch.
// TESTING (WIDTH=2, SETTLE=1 unless noted)
//  Correct comparator model, 1-cycle start -> busy 32 cycles, done=1, pass=1, err_count=0.
//  Model with g stuck 0 -> err_count=6, first_fail=4'b0100, pass=0 after 32 cycles.
//  Model with e stuck 1 -> err_count=12, first_fail=4'b0001; with COMP_BIST_STOP_ON_FAIL_EN:
//   done after vector 0001, err_count=1, a=2'b00, b=2'b01 held.
//  start pulsed while busy -> no effect; start in DONE -> err_count/done cleared, new 32-cycle sweep.
//  rst at vector 4'b0111 -> next cycle IDLE, a=b=0, busy=0, err_count=0; new start completes normally.
//  SETTLE=3, correct model -> busy exactly 64 cycles, e/g/l sampled only in last cycle of each vector.

Source files
------------

// File: rtl/comparator_bist.sv
// Self-test sweep engine for a WIDTH-bit magnitude comparator: drives every {a,b}, checks e/g/l.
// Optional build macro COMP_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module comparator_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic                 e,
  input  logic                 g,
  input  logic                 l,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state_reg, state_next;
  logic [VW-1:0]   vec_reg;
  logic [CW-1:0]   cnt_reg;
  logic [VW:0]     err_reg;
  logic [VW-1:0]   ff_reg;
  logic            mismatch;
  logic            last_vec;

  // Operands come straight from the vector register, so they are registered outputs.
  assign a = vec_reg[VW-1:WIDTH];
  assign b = vec_reg[WIDTH-1:0];
  assign err_count  = err_reg;
  assign first_fail = ff_reg;

  // Any pattern other than the single correct one-hot code is a failure.
  assign mismatch = ({e, g, l} != {a == b, a > b, a < b});
  assign last_vec = (vec_reg == {VW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      if (cnt_reg == CNT_LAST) state_next = SAMPLE;
      SAMPLE: begin
`ifdef COMP_BIST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) state_next = DONE;
        else                      state_next = DRIVE;
`else
        if (last_vec) state_next = DONE;
        else          state_next = DRIVE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == DRIVE) || (state_reg == SAMPLE);
    done = (state_reg == DONE);
    pass = (state_reg == DONE) && (err_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_reg <= '0;
      cnt_reg <= '0;
      err_reg <= '0;
      ff_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            vec_reg <= '0;
            cnt_reg <= '0;
            err_reg <= '0;
            ff_reg  <= '0;
          end
        end
        DRIVE: begin
          if (cnt_reg != CNT_LAST) cnt_reg <= cnt_reg + 1'b1;
        end
        SAMPLE: begin
          cnt_reg <= '0;
          if (mismatch) begin
            err_reg <= err_reg + 1'b1;
            if (err_reg == '0) ff_reg <= vec_reg;
          end
          // Only advance when another vector follows; DONE keeps the last one on a/b.
          if (state_next == DRIVE) vec_reg <= vec_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench for comparator_bist: table of sweeps against behavioural comparator models.
module tb_comparator_bist;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start3 = 1'b0;
  logic [1:0] a1, b1, a3, b3;
  logic       e1, g1, l1, e3, g3, l3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [4:0] err1, err3;
  logic [3:0] ff1, ff3;
  logic [3:0] p1, p2, p3;
  int         mode = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  comparator_bist #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .e(e1), .g(g1), .l(l1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1));

  comparator_bist #(.WIDTH(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .e(e3), .g(g3), .l(l3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3));

  // mode 0: correct, 1: g stuck 0, 2: e stuck 1
  always_comb begin
    e1 = (a1 == b1) || (mode == 2);
    g1 = (a1 > b1) && (mode != 1);
    l1 = (a1 < b1);
  end

  // Slow comparator: result only correct three cycles after the operands change.
  always @(posedge clk) begin
    p1 <= {a3, b3};
    p2 <= p1;
    p3 <= p2;
  end
  always_comb begin
    e3 = (p3[3:2] == p3[1:0]);
    g3 = (p3[3:2] >  p3[1:0]);
    l3 = (p3[3:2] <  p3[1:0]);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start, count busy cycles; optionally re-pulse start at busy cycle inject_at.
  task automatic run_sweep(input int mode_i, input int inject_at, output int cycles);
    mode = mode_i;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cycles = 0;
    while (busy1 && cycles < 2000) begin
      cycles++;
      start1 = (cycles == inject_at);
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  typedef struct {
    int mode; int cyc; int err; int ff; int ps; int ea; int eb;
  } vec_t;

  vec_t tbl[3];
  int   cyc;
  int   rst_mode;

  initial begin
`ifdef COMP_BIST_STOP_ON_FAIL_EN
    tbl[0] = '{0, 32, 0,  0, 1, 3, 3};
    tbl[1] = '{1, 10, 1,  4, 0, 1, 0};
    tbl[2] = '{2,  4, 1,  1, 0, 0, 1};
    rst_mode = 0;
`else
    tbl[0] = '{0, 32, 0,  0, 1, 3, 3};
    tbl[1] = '{1, 32, 6,  4, 0, 3, 3};
    tbl[2] = '{2, 32, 12, 1, 0, 3, 3};
    rst_mode = 1;
`endif

    repeat (3) @(negedge clk);
    chk("reset_busy", busy1, 0);
    chk("reset_done", done1, 0);
    chk("reset_pass", pass1, 0);
    chk("reset_err", err1, 0);
    chk("reset_ff", ff1, 0);
    chk("reset_ab", {a1, b1}, 0);
    rst = 1'b0;
    $display("reset: busy=%0d done=%0d err=%0d", busy1, done1, err1);

    for (int i = 0; i < 3; i++) begin
      run_sweep(tbl[i].mode, 0, cyc);
      $display("sweep mode=%0d: cycles=%0d err=%0d ff=%0d pass=%0d a=%0d b=%0d",
               tbl[i].mode, cyc, err1, ff1, pass1, a1, b1);
      chk("sweep_cycles", cyc, tbl[i].cyc);
      chk("sweep_done", done1, 1);
      chk("sweep_pass", pass1, tbl[i].ps);
      chk("sweep_err", err1, tbl[i].err);
      chk("sweep_ff", ff1, tbl[i].ff);
      chk("sweep_a", a1, tbl[i].ea);
      chk("sweep_b", b1, tbl[i].eb);
    end

    // Restart from DONE with errors pending: status clears on the next cycle.
    mode = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("restart_done", done1, 0);
    chk("restart_err", err1, 0);
    chk("restart_busy", busy1, 1);
    cyc = 0;
    while (busy1 && cyc < 2000) begin cyc++; @(negedge clk); end
    $display("restart: cycles=%0d pass=%0d", cyc, pass1);
    chk("restart_cycles", cyc, 32);
    chk("restart_pass", pass1, 1);

    // start pulsed mid-sweep must not extend or restart it.
    run_sweep(0, 7, cyc);
    $display("start_while_busy: cycles=%0d pass=%0d", cyc, pass1);
    chk("busy_start_cycles", cyc, 32);
    chk("busy_start_pass", pass1, 1);

    // Reset mid-sweep at vector 0111.
    mode = rst_mode;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cyc = 0;
    while ({a1, b1} != 4'b0111 && cyc < 200) begin cyc++; @(negedge clk); end
    chk("reach_0111", {a1, b1}, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("mid_reset: busy=%0d a=%0d b=%0d err=%0d", busy1, a1, b1, err1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_ab", {a1, b1}, 0);
    chk("midrst_err", err1, 0);
    chk("midrst_done", done1, 0);
    run_sweep(0, 0, cyc);
    $display("post_reset sweep: cycles=%0d pass=%0d", cyc, pass1);
    chk("postrst_cycles", cyc, 32);
    chk("postrst_pass", pass1, 1);

    // SETTLE=3 against the slow comparator.
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    cyc = 0;
    while (busy3 && cyc < 2000) begin cyc++; @(negedge clk); end
    $display("settle3: cycles=%0d err=%0d pass=%0d", cyc, err3, pass3);
    chk("s3_cycles", cyc, 64);
    chk("s3_err", err3, 0);
    chk("s3_pass", pass3, 1);
    chk("s3_ff", ff3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
